// File: rtl/lsu_misaligned_ctrl.sv
// lsu_misaligned_ctrl
// Sequences EX-stage loads/stores onto the data bus. Misaligned accesses are
// split into two word-aligned transactions. The second transaction's address
// comes from the ALU, which adds 4 while lsu_addr_incr_req_o is high. Load
// data from both halves is merged, aligned and extended for writeback.
module lsu_misaligned_ctrl #(
    parameter bit ErrSkipSecond = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        lsu_addr_incr_req_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_err_o,
    output logic [31:0] addr_last_o,
    output logic        busy_o
);

    localparam logic [2:0] IDLE            = 3'd0;
    localparam logic [2:0] WAIT_GNT_MIS    = 3'd1;
    localparam logic [2:0] WAIT_RVALID_MIS = 3'd2;
    localparam logic [2:0] WAIT_GNT_MIS2   = 3'd3;
    localparam logic [2:0] WAIT_GNT        = 3'd4;
    localparam logic [2:0] WAIT_RVALID     = 3'd5;

    logic [2:0]  state_q, state_d;
    // The low byte of the first half never reaches the merged result.
    logic [31:8] rdata_q, rdata_d;
    logic [31:0] addrLast_q, addrLast_d;
    logic        errSticky_q, errSticky_d;

    logic [1:0]  offset;
    logic        isWord, isHalf, splitAccess, reqRaw;
    logic [31:0] mergedData;

    assign offset      = adder_result_ex_i[1:0];
    assign isWord      = (lsu_type_i == 2'b00);
    assign isHalf      = (lsu_type_i == 2'b01);
    assign splitAccess = (isWord && offset != 2'd0) || (isHalf && offset == 2'd3);

    // Bus request is forced low while reset is held, even if EX is requesting.
    assign data_req_o  = reqRaw & rst_ni;
    assign data_addr_o = {adder_result_ex_i[31:2], 2'b00};
    assign data_we_o   = lsu_we_i;
    assign addr_last_o = addrLast_q;
    assign busy_o      = (state_q != IDLE);

    // Access sequencing: next state, captured data/address/error and the per-state handshake outputs.
    always_comb begin
        state_d             = state_q;
        rdata_d             = rdata_q;
        addrLast_d          = addrLast_q;
        errSticky_d         = errSticky_q;
        reqRaw              = 1'b0;
        lsu_addr_incr_req_o = 1'b0;
        lsu_resp_valid_o    = 1'b0;
        lsu_err_o           = 1'b0;
        case (state_q)
            IDLE: begin
                reqRaw = lsu_req_i;
                if (lsu_req_i) begin
                    errSticky_d = 1'b0;
                    if (data_gnt_i) begin
                        addrLast_d = adder_result_ex_i;
                        state_d    = splitAccess ? WAIT_RVALID_MIS : WAIT_RVALID;
                    end else begin
                        state_d    = splitAccess ? WAIT_GNT_MIS : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT_MIS: begin
                reqRaw = 1'b1;
                if (data_gnt_i) begin
                    addrLast_d = adder_result_ex_i;
                    state_d    = WAIT_RVALID_MIS;
                end
            end
            WAIT_GNT: begin
                reqRaw = 1'b1;
                if (data_gnt_i) begin
                    addrLast_d = adder_result_ex_i;
                    state_d    = WAIT_RVALID;
                end
            end
            WAIT_RVALID_MIS: begin
                if (data_rvalid_i) begin
                    rdata_d = data_rdata_i[31:8];
                    if (data_err_i && ErrSkipSecond) begin
                        lsu_resp_valid_o = 1'b1;
                        lsu_err_o        = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        errSticky_d = data_err_i;
                        state_d     = WAIT_GNT_MIS2;
                    end
                end
            end
            WAIT_GNT_MIS2: begin
                reqRaw              = 1'b1;
                lsu_addr_incr_req_o = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    lsu_resp_valid_o = 1'b1;
                    lsu_err_o        = data_err_i | errSticky_q;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset may land in any state, including mid-split.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            addrLast_q  <= '0;
            errSticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            addrLast_q  <= addrLast_d;
            errSticky_q <= errSticky_d;
        end
    end

    // Byte enables: the second half covers the bytes that spilled into the next word.
    always_comb begin
        data_be_o = 4'b0000;
        if (state_q == WAIT_GNT_MIS2) begin
            if (isWord) begin
                data_be_o = 4'b1111 >> (3'd4 - {1'b0, offset});
            end else begin
                data_be_o = 4'b0001;
            end
        end else if (isWord) begin
            data_be_o = 4'b1111 << offset;
        end else if (isHalf) begin
            data_be_o = 4'b0011 << offset;
        end else begin
            data_be_o = 4'b0001 << offset;
        end
    end

    // Store data rotated so each byte lands on its lane; the same rotation serves both halves.
    always_comb begin
        case (offset)
            2'd1:    data_wdata_o = {lsu_wdata_i[23:0], lsu_wdata_i[31:24]};
            2'd2:    data_wdata_o = {lsu_wdata_i[15:0], lsu_wdata_i[31:16]};
            2'd3:    data_wdata_o = {lsu_wdata_i[7:0],  lsu_wdata_i[31:8]};
            default: data_wdata_o = lsu_wdata_i;
        endcase
    end

    // Load data: merge both halves (or shift a single word down), then size and extend.
    always_comb begin
        mergedData = data_rdata_i >> {offset, 3'b000};
        if (splitAccess) begin
            case (offset)
                2'd1:    mergedData = {data_rdata_i[7:0],  rdata_q[31:8]};
                2'd2:    mergedData = {data_rdata_i[15:0], rdata_q[31:16]};
                2'd3:    mergedData = {data_rdata_i[23:0], rdata_q[31:24]};
                default: mergedData = data_rdata_i;
            endcase
        end
        if (lsu_we_i) begin
            lsu_rdata_o = 32'h0;
        end else if (isWord) begin
            lsu_rdata_o = mergedData;
        end else if (isHalf) begin
            lsu_rdata_o = {{16{lsu_sign_ext_i & mergedData[15]}}, mergedData[15:0]};
        end else begin
            lsu_rdata_o = {{24{lsu_sign_ext_i & mergedData[7]}}, mergedData[7:0]};
        end
    end

endmodule

// File: tb/tb_lsu_misaligned_ctrl.sv
// tb_lsu_misaligned_ctrl
// Directed bench: a per-cycle vector table for the main access shapes plus
// hand-written sequences for reset mid-split and the ErrSkipSecond=0 variant.
module tb_lsu_misaligned_ctrl;

    typedef struct {
        logic        req, we, sext, gnt, rv, err;
        logic [1:0]  typ;
        logic [31:0] wdata, addr, rdata;
        logic        eReq, eIncr, eResp, eErr, eBusy;
        logic [3:0]  eBe;
        logic [31:0] eAddr, eWdata, eRdata, eLast;
    } vec_t;

    logic        clock;
    logic        rstN;
    logic        lsuReq, lsuReqB, lsuWe, lsuSext;
    logic [1:0]  lsuType;
    logic [31:0] lsuWdata, adderResult, dataRdata;
    logic        dataGnt, dataRvalid, dataErr;

    logic        incrReq, dataReq, dataWe, respValid, lsuErr, busy;
    logic [3:0]  dataBe;
    logic [31:0] dataAddr, dataWdata, lsuRdata, addrLast;

    logic        incrReqB, dataReqB, dataWeB, respValidB, lsuErrB, busyB;
    logic [3:0]  dataBeB;
    logic [31:0] dataAddrB, dataWdataB, lsuRdataB, addrLastB;

    int nChecks = 0;
    int nPass   = 0;
    vec_t vecs[$];

    lsu_misaligned_ctrl #(.ErrSkipSecond(1'b1)) dut (
        .clk_i(clock), .rst_ni(rstN),
        .lsu_req_i(lsuReq), .lsu_we_i(lsuWe), .lsu_type_i(lsuType),
        .lsu_sign_ext_i(lsuSext), .lsu_wdata_i(lsuWdata),
        .adder_result_ex_i(adderResult), .lsu_addr_incr_req_o(incrReq),
        .data_req_o(dataReq), .data_gnt_i(dataGnt), .data_rvalid_i(dataRvalid),
        .data_err_i(dataErr), .data_addr_o(dataAddr), .data_we_o(dataWe),
        .data_be_o(dataBe), .data_wdata_o(dataWdata), .data_rdata_i(dataRdata),
        .lsu_rdata_o(lsuRdata), .lsu_resp_valid_o(respValid), .lsu_err_o(lsuErr),
        .addr_last_o(addrLast), .busy_o(busy)
    );

    lsu_misaligned_ctrl #(.ErrSkipSecond(1'b0)) dutB (
        .clk_i(clock), .rst_ni(rstN),
        .lsu_req_i(lsuReqB), .lsu_we_i(lsuWe), .lsu_type_i(lsuType),
        .lsu_sign_ext_i(lsuSext), .lsu_wdata_i(lsuWdata),
        .adder_result_ex_i(adderResult), .lsu_addr_incr_req_o(incrReqB),
        .data_req_o(dataReqB), .data_gnt_i(dataGnt), .data_rvalid_i(dataRvalid),
        .data_err_i(dataErr), .data_addr_o(dataAddrB), .data_we_o(dataWeB),
        .data_be_o(dataBeB), .data_wdata_o(dataWdataB), .data_rdata_i(dataRdata),
        .lsu_rdata_o(lsuRdataB), .lsu_resp_valid_o(respValidB), .lsu_err_o(lsuErrB),
        .addr_last_o(addrLastB), .busy_o(busyB)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic [31:0] req, we, typ, sext, wdata, addr, gnt, rv, err, rdata,
        input logic [31:0] eReq, eIncr, eBe, eAddr, eWdata, eResp, eErr, eRdata, eBusy, eLast);
        vec_t v;
        v.req = req[0];   v.we = we[0];     v.typ = typ[1:0]; v.sext = sext[0];
        v.wdata = wdata;  v.addr = addr;    v.gnt = gnt[0];   v.rv = rv[0];
        v.err = err[0];   v.rdata = rdata;
        v.eReq = eReq[0]; v.eIncr = eIncr[0]; v.eBe = eBe[3:0]; v.eAddr = eAddr;
        v.eWdata = eWdata; v.eResp = eResp[0]; v.eErr = eErr[0]; v.eRdata = eRdata;
        v.eBusy = eBusy[0]; v.eLast = eLast;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        lsuReq      = v.req;
        lsuWe       = v.we;
        lsuType     = v.typ;
        lsuSext     = v.sext;
        lsuWdata    = v.wdata;
        adderResult = v.addr;
        dataGnt     = v.gnt;
        dataRvalid  = v.rv;
        dataErr     = v.err;
        dataRdata   = v.rdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
        lsuReqB = 1'b0;
    endtask

    // Main stimulus: reset, vector table, then hand-written multi-cycle sequences.
    initial begin
        localparam logic [31:0] W = 32'hAABBCCDD;
        localparam logic [31:0] R = 32'hCCDDAABB;

        // aligned LW 0x1000
        vecs.push_back(mk(1,0,0,0,0,32'h1000,1,0,0,0,               1,0,4'hF,32'h1000,0,0,0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,32'h1000,0,1,0,32'hDEADBEEF,    0,0,0,0,0,1,0,32'hDEADBEEF,1,32'h1000));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,32'h1000));
        // misaligned LW 0x1001
        vecs.push_back(mk(1,0,0,0,0,32'h1001,1,0,0,0,               1,0,4'hE,32'h1000,0,0,0,0,0,32'h1000));
        vecs.push_back(mk(1,0,0,0,0,32'h1001,0,1,0,32'h44332211,    0,0,0,0,0,0,0,0,1,32'h1001));
        vecs.push_back(mk(1,0,0,0,0,32'h1005,1,0,0,0,               1,1,4'h1,32'h1004,0,0,0,0,1,32'h1001));
        vecs.push_back(mk(1,0,0,0,0,32'h1001,0,1,0,32'h88776655,    0,0,0,0,0,1,0,32'h55443322,1,32'h1001));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,32'h1001));
        // LH 0x2003 sign-extended, split
        vecs.push_back(mk(1,0,1,1,0,32'h2003,1,0,0,0,               1,0,4'h8,32'h2000,0,0,0,0,0,32'h1001));
        vecs.push_back(mk(1,0,1,1,0,32'h2003,0,1,0,32'h80123456,    0,0,0,0,0,0,0,0,1,32'h2003));
        vecs.push_back(mk(1,0,1,1,0,32'h2007,1,0,0,0,               1,1,4'h1,32'h2004,0,0,0,0,1,32'h2003));
        vecs.push_back(mk(1,0,1,1,0,32'h2003,0,1,0,32'h123456FF,    0,0,0,0,0,1,0,32'hFFFFFF80,1,32'h2003));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,32'h2003));
        // LHU 0x2002, single access
        vecs.push_back(mk(1,0,1,0,0,32'h2002,1,0,0,0,               1,0,4'hC,32'h2000,0,0,0,0,0,32'h2003));
        vecs.push_back(mk(1,0,1,0,0,32'h2002,0,1,0,32'hBEEF1234,    0,0,0,0,0,1,0,32'h0000BEEF,1,32'h2002));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,32'h2002));
        // SW 0x3002, grant delayed 3 cycles in each phase
        vecs.push_back(mk(1,1,0,0,W,32'h3002,0,0,0,0,               1,0,4'hC,32'h3000,R,0,0,0,0,32'h2002));
        vecs.push_back(mk(1,1,0,0,W,32'h3002,0,0,0,0,               1,0,4'hC,32'h3000,R,0,0,0,1,32'h2002));
        vecs.push_back(mk(1,1,0,0,W,32'h3002,0,0,0,0,               1,0,4'hC,32'h3000,R,0,0,0,1,32'h2002));
        vecs.push_back(mk(1,1,0,0,W,32'h3002,1,0,0,0,               1,0,4'hC,32'h3000,R,0,0,0,1,32'h2002));
        vecs.push_back(mk(1,1,0,0,W,32'h3002,0,1,0,0,               0,0,0,0,0,0,0,0,1,32'h3002));
        vecs.push_back(mk(1,1,0,0,W,32'h3006,0,0,0,0,               1,1,4'h3,32'h3004,R,0,0,0,1,32'h3002));
        vecs.push_back(mk(1,1,0,0,W,32'h3006,0,0,0,0,               1,1,4'h3,32'h3004,R,0,0,0,1,32'h3002));
        vecs.push_back(mk(1,1,0,0,W,32'h3006,0,0,0,0,               1,1,4'h3,32'h3004,R,0,0,0,1,32'h3002));
        vecs.push_back(mk(1,1,0,0,W,32'h3006,1,0,0,0,               1,1,4'h3,32'h3004,R,0,0,0,1,32'h3002));
        vecs.push_back(mk(1,1,0,0,W,32'h3002,0,1,0,0,               0,0,0,0,0,1,0,0,1,32'h3002));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,32'h3002));
        // split LW 0x4002 with first-half error, second half skipped
        vecs.push_back(mk(1,0,0,0,0,32'h4002,1,0,0,0,               1,0,4'hC,32'h4000,0,0,0,0,0,32'h3002));
        vecs.push_back(mk(1,0,0,0,0,32'h4002,0,1,1,32'h12345678,    0,0,0,0,0,1,1,0,1,32'h4002));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,32'h4002));
        // LB 0x5001 sign-extended
        vecs.push_back(mk(1,0,2,1,0,32'h5001,1,0,0,0,               1,0,4'h2,32'h5000,0,0,0,0,0,32'h4002));
        vecs.push_back(mk(1,0,2,1,0,32'h5001,0,1,0,32'h1122F344,    0,0,0,0,0,1,0,32'hFFFFFFF3,1,32'h5001));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,32'h5001));

        // reset state, with EX requesting during reset
        rstN = 1'b0;
        setIdle();
        lsuReq = 1'b1;
        #3;
        checkOutput("rst.req",   32'(dataReq),   32'h0);
        checkOutput("rst.incr",  32'(incrReq),   32'h0);
        checkOutput("rst.resp",  32'(respValid), 32'h0);
        checkOutput("rst.err",   32'(lsuErr),    32'h0);
        checkOutput("rst.busy",  32'(busy),      32'h0);
        checkOutput("rst.last",  addrLast,       32'h0);
        @(negedge clock);
        setIdle();
        rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.req", i),  32'(dataReq),   32'(vecs[i].eReq));
            checkOutput($sformatf("v%0d.incr", i), 32'(incrReq),   32'(vecs[i].eIncr));
            checkOutput($sformatf("v%0d.resp", i), 32'(respValid), 32'(vecs[i].eResp));
            checkOutput($sformatf("v%0d.err", i),  32'(lsuErr),    32'(vecs[i].eErr));
            checkOutput($sformatf("v%0d.busy", i), 32'(busy),      32'(vecs[i].eBusy));
            checkOutput($sformatf("v%0d.last", i), addrLast,       vecs[i].eLast);
            if (vecs[i].eReq) begin
                checkOutput($sformatf("v%0d.be", i),    32'(dataBe),  32'(vecs[i].eBe));
                checkOutput($sformatf("v%0d.addr", i),  dataAddr,     vecs[i].eAddr);
                checkOutput($sformatf("v%0d.wdata", i), dataWdata,    vecs[i].eWdata);
                checkOutput($sformatf("v%0d.we", i),    32'(dataWe),  32'(vecs[i].we));
            end
            if (vecs[i].eResp && !vecs[i].eErr) begin
                checkOutput($sformatf("v%0d.rdata", i), lsuRdata, vecs[i].eRdata);
            end
        end

        // reset asserted while waiting for the first half's rvalid
        @(negedge clock);
        applyStimulus(mk(1,0,0,0,0,32'h6001,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
        #1;
        checkOutput("mrst.req0", 32'(dataReq), 32'h1);
        @(negedge clock);
        dataGnt = 1'b0;
        #1;
        checkOutput("mrst.busy0", 32'(busy), 32'h1);
        rstN = 1'b0;
        #1;
        checkOutput("mrst.busy",  32'(busy),    32'h0);
        checkOutput("mrst.req",   32'(dataReq), 32'h0);
        checkOutput("mrst.incr",  32'(incrReq), 32'h0);
        checkOutput("mrst.last",  addrLast,     32'h0);
        @(negedge clock);
        rstN       = 1'b1;
        lsuReq     = 1'b0;
        dataRvalid = 1'b1;
        dataRdata  = 32'h99999999;
        #1;
        checkOutput("mrst.late.resp", 32'(respValid), 32'h0);
        @(negedge clock);
        dataRvalid = 1'b0;
        #1;
        checkOutput("mrst.idle.busy", 32'(busy),      32'h0);
        checkOutput("mrst.idle.resp", 32'(respValid), 32'h0);
        @(negedge clock);
        applyStimulus(mk(1,0,0,0,0,32'h7000,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
        #1;
        checkOutput("post.be",  32'(dataBe), 32'hF);
        checkOutput("post.req", 32'(dataReq), 32'h1);
        @(negedge clock);
        applyStimulus(mk(1,0,0,0,0,32'h7000,0,1,0,32'hCAFEF00D, 0,0,0,0,0,0,0,0,0,0));
        #1;
        checkOutput("post.resp",  32'(respValid), 32'h1);
        checkOutput("post.rdata", lsuRdata,       32'hCAFEF00D);
        @(negedge clock);
        setIdle();
        #1;
        checkOutput("post.busy", 32'(busy), 32'h0);

        // ErrSkipSecond=0: split LW 0x8003, error on first half, second half still issued
        @(negedge clock);
        applyStimulus(mk(0,0,0,0,0,32'h8003,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
        lsuReqB = 1'b1;
        #1;
        checkOutput("b.req1", 32'(dataReqB), 32'h1);
        checkOutput("b.be1",  32'(dataBeB),  32'h8);
        @(negedge clock);
        dataGnt = 1'b0; dataRvalid = 1'b1; dataErr = 1'b1; dataRdata = 32'h0;
        #1;
        checkOutput("b.resp1", 32'(respValidB), 32'h0);
        checkOutput("a.ignore", 32'(respValid), 32'h0);
        @(negedge clock);
        adderResult = 32'h8007; dataGnt = 1'b1; dataRvalid = 1'b0; dataErr = 1'b0;
        #1;
        checkOutput("b.req2",  32'(dataReqB), 32'h1);
        checkOutput("b.incr2", 32'(incrReqB), 32'h1);
        checkOutput("b.addr2", dataAddrB,     32'h8004);
        checkOutput("b.be2",   32'(dataBeB),  32'h7);
        @(negedge clock);
        adderResult = 32'h8003; dataGnt = 1'b0; dataRvalid = 1'b1;
        #1;
        checkOutput("b.resp2", 32'(respValidB), 32'h1);
        checkOutput("b.err2",  32'(lsuErrB),    32'h1);
        @(negedge clock);
        setIdle();
        #1;
        checkOutput("b.busy", 32'(busyB), 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
